// File: rtl/alarme_cinto_seq.sv
// -----------------------------------------------------------------------------
// alarme_cinto_seq
//
// Seatbelt reminder sequencer. Synchronizes and debounces the raw cabin sensors
// (seat occupied, belt latched, ignition), then escalates the reminder while a
// driver is seated with the ignition on and the belt unlatched:
//   MONITOR -> AVISO (steady lamp) -> ALERTA (blinking lamp + buzzer)
//           -> SILENCIO (steady lamp, buzzer off)
// Latching the belt drops back to MONITOR; ignition off drops to DESLIGADO.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous, active-high reset
//   motorista  in   raw seat-occupied sensor (asynchronous to clk)
//   cinto      in   raw belt-latched sensor (asynchronous to clk)
//   ignicao    in   raw ignition sensor (asynchronous to clk)
//   luz        out  dashboard warning lamp
//   buzina     out  buzzer enable
//   estado     out  current state (debug): 0 DESLIGADO, 1 MONITOR, 2 AVISO,
//                   3 ALERTA, 4 SILENCIO
// -----------------------------------------------------------------------------
module alarme_cinto_seq #(
    parameter int DEB_CYC    = 4,
    parameter int T_AVISO    = 16,
    parameter int T_ALERTA   = 64,
    parameter int BLINK_HALF = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       motorista,
    input  logic       cinto,
    input  logic       ignicao,
    output logic       luz,
    output logic       buzina,
    output logic [2:0] estado
);

    localparam logic [2:0] DESLIGADO = 3'd0;
    localparam logic [2:0] MONITOR   = 3'd1;
    localparam logic [2:0] AVISO     = 3'd2;
    localparam logic [2:0] ALERTA    = 3'd3;
    localparam logic [2:0] SILENCIO  = 3'd4;

    localparam int TMR_MAX = (T_AVISO > T_ALERTA) ? T_AVISO : T_ALERTA;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int DEB_W   = $clog2(DEB_CYC + 1);
    localparam int BLK_W   = $clog2(BLINK_HALF + 1);

    localparam logic [TMR_W-1:0] TMR_SAT     = TMR_W'(TMR_MAX);
    localparam logic [TMR_W-1:0] AVISO_LAST  = TMR_W'(T_AVISO - 1);
    localparam logic [TMR_W-1:0] ALERTA_LAST = TMR_W'(T_ALERTA - 1);
    localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEB_CYC - 1);
    localparam logic [BLK_W-1:0] BLK_LAST    = BLK_W'(BLINK_HALF - 1);

    // Bit order used throughout the input path: {motorista, cinto, ignicao}
    logic [2:0] raw;
    logic [2:0] sync_p0;
    logic [2:0] sync_p1;
    logic [2:0] deb;

    logic       m_d;
    logic       c_d;
    logic       i_d;
    logic       cond;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [TMR_W-1:0] timer;
    logic             blink;
    logic [BLK_W-1:0] blink_cnt;

    assign raw = {motorista, cinto, ignicao};

    // ---- stage p0/p1: two-flop synchronizer ----
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 3'b000;
            sync_p1 <= 3'b000;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // ---- debouncer: accept a new level only after DEB_CYC consecutive disagreeing edges ----
    for (genvar k = 0; k < 3; k++) begin : g_deb
        logic [DEB_W-1:0] cnt;
        logic             q;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
                q   <= 1'b0;
            end else if (sync_p1[k] == q) begin
                // Any agreeing edge restarts the count, so short glitches are dropped.
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                q   <= sync_p1[k];
                cnt <= '0;
            end else begin
                cnt <= cnt + DEB_W'(1);
            end
        end

        assign deb[k] = q;
    end

    assign m_d  = deb[2];
    assign c_d  = deb[1];
    assign i_d  = deb[0];
    assign cond = m_d & ~c_d & i_d;

    // ---- FSM next state: earlier branches take priority ----
    always_comb begin
        state_nxt = state;
        if (!i_d) begin
            state_nxt = DESLIGADO;
        end else if (state == DESLIGADO) begin
            state_nxt = MONITOR;
        end else if (((state == AVISO) || (state == ALERTA) || (state == SILENCIO)) && !cond) begin
            // Belt latched (or seat empty) beats a timer expiry on the same edge.
            state_nxt = MONITOR;
        end else if ((state == MONITOR) && cond) begin
            state_nxt = AVISO;
        end else if ((state == AVISO) && (timer == AVISO_LAST)) begin
            state_nxt = ALERTA;
        end else if ((state == ALERTA) && (timer == ALERTA_LAST)) begin
            state_nxt = SILENCIO;
        end else if (state > SILENCIO) begin
            // Unused encodings recover to the idle state.
            state_nxt = DESLIGADO;
        end
    end

    // ---- state register and dwell timer ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DESLIGADO;
            timer <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                timer <= '0;
            end else if (timer != TMR_SAT) begin
                timer <= timer + TMR_W'(1);
            end
        end
    end

    // ---- blink phase: starts lit on ALERTA entry, held lit outside ALERTA ----
    always_ff @(posedge clk) begin
        if (rst) begin
            blink     <= 1'b1;
            blink_cnt <= '0;
        end else if ((state == ALERTA) && (state_nxt == ALERTA)) begin
            if (blink_cnt == BLK_LAST) begin
                blink     <= ~blink;
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + BLK_W'(1);
            end
        end else begin
            blink     <= 1'b1;
            blink_cnt <= '0;
        end
    end

    // ---- output decode of registered state ----
    always_comb begin
        luz    = 1'b0;
        buzina = 1'b0;
        case (state)
            AVISO:    luz = 1'b1;
            ALERTA: begin
                luz    = blink;
                buzina = 1'b1;
            end
            SILENCIO: luz = 1'b1;
            default: begin
                luz    = 1'b0;
                buzina = 1'b0;
            end
        endcase
    end

    assign estado = state;

endmodule

// File: tb/tb_alarme_cinto_seq.sv
// -----------------------------------------------------------------------------
// tb_alarme_cinto_seq
//
// Directed bench for alarme_cinto_seq (DEB_CYC=4, T_AVISO=16, T_ALERTA=64,
// BLINK_HALF=4). Edge numbers count rising edges since reset was released
// (edge 0 is the reset edge). Stimulus pushes {edge, estado, luz, buzina}
// expectations into a queue; the monitor pops and compares when the DUT
// reaches that edge.
// -----------------------------------------------------------------------------
module tb_alarme_cinto_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       motorista = 1'b0;
    logic       cinto = 1'b0;
    logic       ignicao = 1'b0;
    logic       luz;
    logic       buzina;
    logic [2:0] estado;

    always #5 clk = ~clk;

    alarme_cinto_seq #(
        .DEB_CYC   (4),
        .T_AVISO   (16),
        .T_ALERTA  (64),
        .BLINK_HALF(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .motorista(motorista),
        .cinto    (cinto),
        .ignicao  (ignicao),
        .luz      (luz),
        .buzina   (buzina),
        .estado   (estado)
    );

    typedef struct {
        int         e;
        logic [2:0] st;
        logic       lz;
        logic       bz;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   edge_n   = 0;
    int   phase    = 1;
    int   checks   = 0;
    int   failures = 0;

    // Edge counter restarts on every reset edge.
    always @(posedge clk) edge_n <= rst ? 0 : edge_n + 1;

    // Monitor: sample 1 time unit after the edge, compare against queue head.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0 && sb[0].e == edge_n) begin
            cur = sb.pop_front();
            checks++;
            if ({estado, luz, buzina} !== {cur.st, cur.lz, cur.bz}) begin
                failures++;
                $display("FAIL ph%0d edge%0d estado/luz/buzina: got %0d/%b/%b expected %0d/%b/%b",
                         phase, cur.e, estado, luz, buzina, cur.st, cur.lz, cur.bz);
            end
        end else if (sb.size() > 0 && sb[0].e < edge_n) begin
            cur = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL ph%0d edge%0d skipped: got edge %0d expected edge %0d",
                     phase, cur.e, edge_n, cur.e);
        end
    end

    task automatic push(input int e, input logic [2:0] st, input logic lz, input logic bz);
        exp_t t;
        t.e  = e;
        t.st = st;
        t.lz = lz;
        t.bz = bz;
        sb.push_back(t);
    endtask

    // Returns at the falling edge that follows rising edge n.
    task automatic at_neg(input int n);
        while (edge_n < n) @(negedge clk);
    endtask

    // Ignition seen from edge 1, seat sensor first sampled at edge 7:
    // MONITOR at 7, AVISO at 13, ALERTA at 29 (blink 1111 0000 ...), SILENCIO at 93.
    task automatic push_scen1();
        push(0, 3'd0, 1'b0, 1'b0);
        push(6, 3'd0, 1'b0, 1'b0);
        push(7, 3'd1, 1'b0, 1'b0);
        push(12, 3'd1, 1'b0, 1'b0);
        push(13, 3'd2, 1'b1, 1'b0);
        push(28, 3'd2, 1'b1, 1'b0);
        for (int e = 29; e <= 92; e++)
            push(e, 3'd3, ((((e - 29) / 4) % 2) == 0), 1'b1);
        push(93, 3'd4, 1'b1, 1'b0);
        push(100, 3'd4, 1'b1, 1'b0);
    endtask

    initial begin
        push_scen1();
        // Belt latched in SILENCIO (sampled 101) -> MONITOR at 107; released (sampled 111) -> AVISO at 117
        push(106, 3'd4, 1'b1, 1'b0);
        push(107, 3'd1, 1'b0, 1'b0);
        push(116, 3'd1, 1'b0, 1'b0);
        push(117, 3'd2, 1'b1, 1'b0);
        // 3-cycle belt glitch (sampled 119..121) rejected; AVISO runs full 16 cycles
        push(124, 3'd2, 1'b1, 1'b0);
        push(132, 3'd2, 1'b1, 1'b0);
        push(133, 3'd3, 1'b1, 1'b1);
        // Ignition off and belt latched together (sampled 141) -> DESLIGADO at 147
        push(146, 3'd3, 1'b0, 1'b1);
        push(147, 3'd0, 1'b0, 1'b0);
        // Ignition back, belt open (sampled 151) -> MONITOR 157, AVISO 158
        push(156, 3'd0, 1'b0, 1'b0);
        push(157, 3'd1, 1'b0, 1'b0);
        push(158, 3'd2, 1'b1, 1'b0);
        // 6-cycle belt pulse (sampled 161..166) -> MONITOR at 167, back to AVISO at 173
        push(166, 3'd2, 1'b1, 1'b0);
        push(167, 3'd1, 1'b0, 1'b0);
        push(172, 3'd1, 1'b0, 1'b0);
        push(173, 3'd2, 1'b1, 1'b0);
        push(188, 3'd2, 1'b1, 1'b0);
        push(189, 3'd3, 1'b1, 1'b1);
        push(192, 3'd3, 1'b1, 1'b1);

        rst     = 1'b1;
        ignicao = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        at_neg(6);   motorista = 1'b1;
        at_neg(100); cinto = 1'b1;
        at_neg(110); cinto = 1'b0;
        at_neg(118); cinto = 1'b1;
        at_neg(121); cinto = 1'b0;
        at_neg(140); ignicao = 1'b0; cinto = 1'b1;
        at_neg(150); ignicao = 1'b1; cinto = 1'b0;
        at_neg(160); cinto = 1'b1;
        at_neg(166); cinto = 1'b0;

        // One-cycle reset in the middle of ALERTA, then the scenario-1 sequence again.
        at_neg(192);
        phase     = 2;
        rst       = 1'b1;
        motorista = 1'b0;
        push_scen1();
        @(negedge clk);
        rst = 1'b0;
        at_neg(6);   motorista = 1'b1;
        at_neg(102);

        while (sb.size() > 0) begin
            cur = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL ph%0d edge%0d unchecked: got no sample expected %0d/%b/%b",
                     phase, cur.e, cur.st, cur.lz, cur.bz);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
